// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// State encoding, default operand widths and counter width.
package div_pkg;

   localparam int DW_N_DEF = 16;
   localparam int DW_D_DEF = 8;
   localparam int CNT_W_DEF = $clog2(DW_N_DEF);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ROUND,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
// Ports: rem/nbit/divisor in; rem_next (new partial rem), q (quotient bit) out.
module div_restore_step #(
   parameter int DW_D = div_pkg::DW_D_DEF
) (
   input  logic [DW_D-1:0] rem,
   input  logic            nbit,
   input  logic [DW_D-1:0] divisor,
   output logic [DW_D-1:0] rem_next,
   output logic            q
);

   logic [DW_D:0] part;
   logic [DW_D:0] diff;
   logic          diff_unused;

   assign part = {rem, nbit};
   assign diff = part - {1'b0, divisor};
   assign q = (part >= {1'b0, divisor});
   // rem < divisor on entry, so a kept difference always fits in DW_D bits
   assign rem_next = q ? diff[DW_D-1:0] : part[DW_D-1:0];
   assign diff_unused = diff[DW_D];

endmodule

// File: rtl/unsigned_div16by8_seq.sv
// Sequential unsigned restoring divider, DW_N / DW_D, one quotient bit per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + dividend, divisor;
//   out_valid/out_ready + quotient, remainder, div_by_zero.
// Macro DIV_ROUND_EN adds a one-cycle ROUND state (round-half-up quotient).
module unsigned_div16by8_seq
   import div_pkg::*;
#(
   parameter int DW_N = DW_N_DEF,
   parameter int DW_D = DW_D_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW_N-1:0] dividend,
   input  logic [DW_D-1:0] divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW_N-1:0] quotient,
   output logic [DW_D-1:0] remainder,
   output logic            div_by_zero
);

   localparam int CW = $clog2(DW_N);

   div_state_t      state, state_n;
   logic [CW-1:0]   cnt;
   logic [DW_N-1:0] dvd;
   logic [DW_D-1:0] dsr;
   logic [DW_D-1:0] rem;
   logic [DW_N-1:0] quo;
   logic            dbz;
   logic [DW_D-1:0] step_rem;
   logic            step_q;

   div_restore_step #(
      .DW_D(DW_D)
   ) u_step (
      .rem     (rem),
      .nbit    (dvd[DW_N-1]),
      .divisor (dsr),
      .rem_next(step_rem),
      .q       (step_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = (divisor == '0) ? DONE : CALC;
         end
         CALC: begin
            if (cnt == '0) begin
`ifdef DIV_ROUND_EN
               state_n = ROUND;
`else
               state_n = DONE;
`endif
            end
         end
         ROUND: state_n = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         dvd <= '0;
         dsr <= '0;
         rem <= '0;
         quo <= '0;
         dbz <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd <= dividend;
                  dsr <= divisor;
                  if (divisor == '0) begin
                     quo <= '1;
                     rem <= dividend[DW_D-1:0];
                     dbz <= 1'b1;
                  end else begin
                     quo <= '0;
                     rem <= '0;
                     dbz <= 1'b0;
                     cnt <= CW'(DW_N - 1);
                  end
               end
            end
            CALC: begin
               rem <= step_rem;
               quo <= {quo[DW_N-2:0], step_q};
               dvd <= {dvd[DW_N-2:0], 1'b0};
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
`ifdef DIV_ROUND_EN
            ROUND: begin
               // 2*rem >= divisor: round up, remainder goes negative mod 2^DW_D
               if ({rem, 1'b0} >= {1'b0, dsr}) begin
                  if (quo != '1) quo <= quo + 1'b1;
                  rem <= rem - dsr;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign quotient    = quo;
   assign remainder   = rem;
   assign div_by_zero = dbz;

endmodule

// File: tb/tb_unsigned_div16by8_seq.sv
// Self-checking bench for unsigned_div16by8_seq: directed cases then
// random traffic, expected results queued at accept and checked at output.
module tb_unsigned_div16by8_seq;

   localparam int DW_N = 16;
   localparam int DW_D = 8;
`ifdef DIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif
   localparam int LAT = DW_N + 1 + RND;
   localparam int NR  = 1200;

   typedef struct packed {
      logic [15:0] n;
      logic [7:0]  d;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   drv_done = 1'b0;

   always #5 clk = ~clk;

   unsigned_div16by8_seq #(
      .DW_N(DW_N),
      .DW_D(DW_D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic [15:0] n,
                                  input logic [7:0] d);
      exp_t e;
      e.n = n;
      e.d = d;
      if (d == 8'd0) begin
         e.q = 16'hFFFF;
         e.r = n[7:0];
         e.z = 1'b1;
      end else begin
         e.q = 16'(int'(n) / int'(d));
         e.r = 8'(int'(n) % int'(d));
         e.z = 1'b0;
         if (RND != 0 && 2 * int'(e.r) >= int'(d)) begin
            if (e.q != 16'hFFFF) e.q = e.q + 16'd1;
            e.r = e.r - d;
         end
      end
      return e;
   endfunction

   task automatic check_out(input string tag);
      exp_t e;
      chk({tag, ".sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".q"}, 32'(quotient), 32'(e.q));
         chk({tag, ".r"}, 32'(remainder), 32'(e.r));
         chk({tag, ".z"}, 32'(div_by_zero), 32'(e.z));
         if (RND == 0 && !e.z) begin
            chk({tag, ".inv"},
                32'(quotient) * 32'(divisor_of(e)) + 32'(remainder),
                32'(e.n));
            chk({tag, ".rlt"}, 32'(remainder < e.d), 32'd1);
         end
      end
   endtask

   function automatic logic [7:0] divisor_of(input exp_t e);
      return e.d;
   endfunction

   task automatic run_op(input string tag, input logic [15:0] n,
                         input logic [7:0] d, input int hold,
                         input int lat);
      int cyc;
      @(negedge clk);
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
      sb.push_back(model(n, d));
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".lat"}, 32'(cyc), 32'(lat));
      if (hold > 0) begin
         in_valid = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            chk({tag, ".hv"}, 32'(out_valid), 32'd1);
            chk({tag, ".hq"}, 32'(quotient), 32'(sb[0].q));
            chk({tag, ".hr"}, 32'(remainder), 32'(sb[0].r));
            chk({tag, ".hbusy"}, 32'(in_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      check_out(tag);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, ".idle"}, 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst.rdy", 32'(in_ready), 32'd1);
      chk("rst.ov", 32'(out_valid), 32'd0);
      chk("rst.q", 32'(quotient), 32'd0);
      chk("rst.r", 32'(remainder), 32'd0);
      chk("rst.z", 32'(div_by_zero), 32'd0);

      run_op("d1000_7", 16'd1000, 8'd7, 0, LAT);
      run_op("dffff_ff", 16'hFFFF, 8'hFF, 0, LAT);
      run_op("dffff_1", 16'hFFFF, 8'd1, 0, LAT);
      run_op("dz1234", 16'h1234, 8'd0, 0, 1);
      run_op("d100_7h", 16'd100, 8'd7, 10, LAT);
      run_op("d0_3", 16'd0, 8'd3, 0, LAT);

      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst.rdy", 32'(in_ready), 32'd1);
      chk("mrst.ov", 32'(out_valid), 32'd0);
      chk("mrst.q", 32'(quotient), 32'd0);
      chk("mrst.r", 32'(remainder), 32'd0);
      run_op("d50_5", 16'd50, 8'd5, 0, LAT);

      fork
         begin
            int g;
            for (int i = 0; i < NR; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               dividend = 16'($urandom);
               divisor  = ($urandom_range(0, 15) == 0) ? 8'd0
                                                      : 8'($urandom);
               in_valid = 1'b1;
               g = 0;
               while (!in_ready && g < 200) begin
                  @(negedge clk);
                  g++;
               end
               chk("rnd.acc", 32'(in_ready), 32'd1);
               if (in_ready) sb.push_back(model(dividend, divisor));
               @(negedge clk);
               in_valid = 1'b0;
            end
            drv_done = 1'b1;
         end
         begin
            int g;
            g = 0;
            while (!(drv_done && sb.size() == 0) && g < 60000) begin
               @(negedge clk);
               g++;
               out_ready = ($urandom_range(0, 2) != 0);
               if (out_valid && out_ready) check_out("rnd");
            end
            out_ready = 1'b0;
         end
      join
      chk("sb.drain", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
